// File: rtl/cdb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_pkg
// Shared constants for the common-data-bus arbiter and its per-source queues.
//   CDB_ROB_W     : ROB tag width (mirrors the `ROB_R range width of the core).
//   CDB_NSRC      : number of result producers feeding the CDB.
//   CDB_SRC_ALU   : producer index of the ALU in the reservation station.
//   CDB_SRC_LSB   : producer index of the load/store buffer.
//   CDB_SRC_SPARE : producer index reserved for a future unit.
//   CDB_QDEPTH    : default entries per source queue (power of two, >= 2).
// rr_next() gives the round-robin successor of a granted source index.
// -----------------------------------------------------------------------------
package cdb_arbiter_pkg;

  localparam int CDB_ROB_W     = 4;
  localparam int CDB_NSRC      = 3;
  localparam int CDB_SRC_ALU   = 0;
  localparam int CDB_SRC_LSB   = 1;
  localparam int CDB_SRC_SPARE = 2;
  localparam int CDB_QDEPTH    = 2;

  function automatic int unsigned rr_next(input int unsigned k, input int unsigned n);
    return (k + 1) % n;
  endfunction

endpackage

// File: rtl/cdb_fifo.sv
// -----------------------------------------------------------------------------
// cdb_fifo
// Small FIFO holding results of one CDB producer until they win the bus.
// Ports:
//   clk   : clock, all updates on posedge
//   rst   : synchronous active-high reset, overrides en
//   en    : global ready; low freezes pointers, count and storage
//   flush : empties the queue (only when en is high)
//   push  : write din at the tail (caller guarantees not full)
//   din   : entry to write
//   pop   : drop the head entry (caller guarantees not empty)
//   head  : entry at the read pointer
//   count : number of stored entries (0..DEPTH)
//   full  : count == DEPTH
// Pointers are log2(DEPTH) bits and wrap naturally because DEPTH is a power
// of two; count carries the extra bit to tell full from empty.
// -----------------------------------------------------------------------------
module cdb_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (en) begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Storage needs no reset: an entry is only observed after it was written.
  always_ff @(posedge clk) begin
    if (en && !rst && !flush && push) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];
  assign full = (count == CW'(DEPTH));

endmodule

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Collects result broadcasts from N_SRC producers into per-source queues and
// drives one shared common data bus (one tag/value per cycle).
// Optional feature macro: CDB_RR_EN
//   defined   : round-robin arbitration starting at rr_ptr
//   undefined : fixed priority, lowest source index wins
// Ports:
//   clk_in     : clock
//   rst_in     : synchronous active-high reset (same effect as rob_clear)
//   rdy_in     : global ready; low freezes all state, hides bus and readies
//   rob_clear  : misprediction flush (acts only while rdy_in is high)
//   src_valid  : per-source result valid
//   src_rob_id : per-source tag, source k at [k*ROB_W +: ROB_W]
//   src_value  : per-source value, source k at [k*32 +: 32]
//   src_ready  : per-source queue not full (and rdy_in high)
//   cdb_valid  : broadcast valid
//   cdb_rob_id : broadcast tag
//   cdb_value  : broadcast value
//
// Handshake: a producer result is taken at the posedge where
// src_valid[k] && src_ready[k] && !rob_clear; while src_valid is high and
// src_ready is low the producer holds tag and value unchanged. src_ready is
// derived from the registered count only. The CDB side has no back-pressure:
// every cycle with cdb_valid high pops the granted queue.
// -----------------------------------------------------------------------------
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N_SRC  = CDB_NSRC,
  parameter int QDEPTH = CDB_QDEPTH,
  parameter int ROB_W  = CDB_ROB_W
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   rob_clear,
  input  logic [N_SRC-1:0]       src_valid,
  input  logic [N_SRC*ROB_W-1:0] src_rob_id,
  input  logic [N_SRC*32-1:0]    src_value,
  output logic [N_SRC-1:0]       src_ready,
  output logic                   cdb_valid,
  output logic [ROB_W-1:0]       cdb_rob_id,
  output logic [31:0]            cdb_value
);

  localparam int EW = ROB_W + 32;
  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [EW-1:0]    head  [N_SRC];
  logic [CW-1:0]    count [N_SRC];
  logic [N_SRC-1:0] full;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] push;
  logic [N_SRC-1:0] pop;
  logic [IW-1:0]    grant_idx;
  logic [IW-1:0]    out_idx;
  logic             any_eligible;

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    assign eligible[g]  = (count[g] != '0);
    assign src_ready[g] = rdy_in && !full[g];
    assign push[g]      = src_valid[g] && src_ready[g] && !rob_clear;
    assign pop[g]       = cdb_valid && !rob_clear && (grant_idx == IW'(g));

    cdb_fifo #(
      .WIDTH (EW),
      .DEPTH (QDEPTH)
    ) u_fifo (
      .clk   (clk_in),
      .rst   (rst_in),
      .en    (rdy_in),
      .flush (rob_clear),
      .push  (push[g]),
      .din   ({src_rob_id[g*ROB_W +: ROB_W], src_value[g*32 +: 32]}),
      .pop   (pop[g]),
      .head  (head[g]),
      .count (count[g]),
      .full  (full[g])
    );
  end

  assign any_eligible = |eligible;
  assign cdb_valid    = rdy_in && any_eligible;

`ifdef CDB_RR_EN
  // rr_ptr names the source searched first; it moves past each winner.
  logic [IW-1:0] rr_ptr;

  always_comb begin
    int  idx;
    logic found;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int off = 0; off < N_SRC; off++) begin
      idx = (int'(rr_ptr) + off) % N_SRC;
      if (!found && eligible[idx]) begin
        grant_idx = IW'(idx);
        found     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rr_ptr <= '0;
    end else if (rdy_in) begin
      if (rob_clear)         rr_ptr <= '0;
      else if (any_eligible) rr_ptr <= IW'(rr_next(int'(grant_idx), N_SRC));
    end
  end
`else
  // Descending scan so the lowest eligible index is the last assignment.
  always_comb begin
    grant_idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) grant_idx = IW'(i);
    end
  end
`endif

  // With nothing to send the data lines simply follow source 0's head.
  assign out_idx                 = cdb_valid ? grant_idx : '0;
  assign {cdb_rob_id, cdb_value} = head[out_idx];

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
// Bench for cdb_arbiter (N_SRC=3, QDEPTH=2, ROB_W=4). A queue-per-source model
// predicts readies, bus valid and the broadcast entry every cycle; directed
// scenarios add literal expectations, then a randomized phase runs with
// producers that hold their result until it is accepted.
// Builds for either arbitration mode (CDB_RR_EN defined or not).
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;

  localparam int NS = 3;
  localparam int QD = 2;
  localparam int RW = 4;
  localparam int EW = RW + 32;

  logic             clk_in = 1'b0;
  logic             rst_in;
  logic             rdy_in;
  logic             rob_clear;
  logic [NS-1:0]    src_valid;
  logic [NS*RW-1:0] src_rob_id;
  logic [NS*32-1:0] src_value;
  logic [NS-1:0]    src_ready;
  logic             cdb_valid;
  logic [RW-1:0]    cdb_rob_id;
  logic [31:0]      cdb_value;

  cdb_arbiter #(
    .N_SRC  (NS),
    .QDEPTH (QD),
    .ROB_W  (RW)
  ) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .rob_clear  (rob_clear),
    .src_valid  (src_valid),
    .src_rob_id (src_rob_id),
    .src_value  (src_value),
    .src_ready  (src_ready),
    .cdb_valid  (cdb_valid),
    .cdb_rob_id (cdb_rob_id),
    .cdb_value  (cdb_value)
  );

  // ---------------- clock ----------------
  always #5 clk_in = ~clk_in;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q [NS][$];
  int            m_rr;
  logic          model_on;
  int            n_checks;
  int            n_fail;

  logic          last_valid;
  logic [RW-1:0] last_rob;
  logic [31:0]   last_value;
  logic [NS-1:0] last_ready;
  logic [NS-1:0] last_acc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: compare outputs against the model mid-cycle, then apply
  // the cycle's effect to the model at the posedge.
  task automatic step();
    int            w;
    int            k;
    logic [NS-1:0] er;
    logic          ev;
    logic [EW-1:0] h;
    @(negedge clk_in);
    w = -1;
    for (int i = 0; i < NS; i++) er[i] = rdy_in && (exp_q[i].size() != QD);
    if (rdy_in) begin
`ifdef CDB_RR_EN
      for (int off = 0; off < NS; off++) begin
        k = (m_rr + off) % NS;
        if (w < 0 && exp_q[k].size() > 0) w = k;
      end
`else
      for (int i = NS - 1; i >= 0; i--) if (exp_q[i].size() > 0) w = i;
`endif
    end
    ev = (w >= 0);
    if (model_on) begin
      check("src_ready", 64'(src_ready), 64'(er));
      check("cdb_valid", 64'(cdb_valid), 64'(ev));
      if (ev) begin
        h = exp_q[w][0];
        check("cdb_rob_id", 64'(cdb_rob_id), 64'(h[EW-1:32]));
        check("cdb_value", 64'(cdb_value), 64'(h[31:0]));
      end
    end
    last_valid = cdb_valid;
    last_rob   = cdb_rob_id;
    last_value = cdb_value;
    last_ready = src_ready;
    last_acc   = src_valid & er & {NS{!rob_clear}};
    @(posedge clk_in);
    if (rst_in) begin
      for (int i = 0; i < NS; i++) exp_q[i].delete();
      m_rr     = 0;
      last_acc = '0;
    end else if (rdy_in) begin
      if (rob_clear) begin
        for (int i = 0; i < NS; i++) exp_q[i].delete();
        m_rr = 0;
      end else begin
        if (w >= 0) begin
          void'(exp_q[w].pop_front());
          m_rr = (w + 1) % NS;
        end
        for (int i = 0; i < NS; i++)
          if (last_acc[i]) exp_q[i].push_back({src_rob_id[i*RW +: RW], src_value[i*32 +: 32]});
      end
    end
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_src(input int k, input logic v, input logic [RW-1:0] rob, input logic [31:0] val);
    src_valid[k]            = v;
    src_rob_id[k*RW +: RW]  = rob;
    src_value[k*32 +: 32]   = val;
  endtask

  task automatic idle();
    src_valid = '0;
  endtask

  task automatic do_clear();
    idle();
    rdy_in    = 1'b1;
    rob_clear = 1'b1;
    step();
    rob_clear = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    logic          saw9;
    logic          r0_low;
    logic          dropped;
    logic [NS-1:0] pend;
    int            seq0;
    int            seq1;

    n_checks   = 0;
    n_fail     = 0;
    m_rr       = 0;
    model_on   = 1'b0;
    rst_in     = 1'b1;
    rdy_in     = 1'b0;
    rob_clear  = 1'b0;
    src_valid  = '0;
    src_rob_id = '0;
    src_value  = '0;

    // Reset for two cycles, then raise rdy_in.
    step();
    model_on = 1'b1;
    step();
    rst_in = 1'b0;
    rdy_in = 1'b1;
    step();
    check("reset_cdb_valid", 64'(last_valid), 64'd0);
    check("reset_src_ready", 64'(last_ready), 64'b111);

    // Single push on source 1.
    set_src(1, 1'b1, 4'd5, 32'h1234);
    step();
    idle();
    step();
    check("single_valid", 64'(last_valid), 64'd1);
    check("single_rob", 64'(last_rob), 64'd5);
    check("single_value", 64'(last_value), 64'h1234);
    step();
    check("single_idle", 64'(last_valid), 64'd0);

    // Three-way collision: tags 1, 2, 3 on consecutive cycles.
    do_clear();
    set_src(0, 1'b1, 4'd1, 32'h100);
    set_src(1, 1'b1, 4'd2, 32'h200);
    set_src(2, 1'b1, 4'd3, 32'h300);
    step();
    idle();
    for (int c = 1; c <= 3; c++) begin
      step();
      check("coll_valid", 64'(last_valid), 64'd1);
      check("coll_rob", 64'(last_rob), 64'(c));
    end
    step();
    check("coll_idle", 64'(last_valid), 64'd0);

    // Contention: src0 streams, src2 sends rob 9 once.
    do_clear();
    saw9   = 1'b0;
    r0_low = 1'b0;
    seq0   = 0;
    for (int c = 0; c < 6; c++) begin
      set_src(0, 1'b1, RW'(seq0 + 10), 32'(32'hA000 + seq0));
      if (c == 0) set_src(2, 1'b1, 4'd9, 32'h99);
      else        src_valid[2] = 1'b0;
      step();
      if (last_acc[0]) seq0++;
      if (last_valid && last_rob == 4'd9) saw9 = 1'b1;
      if (!last_ready[0]) r0_low = 1'b1;
`ifdef CDB_RR_EN
      if (c == 2) check("rr_rob9_by_cycle2", 64'(saw9), 64'd1);
`endif
    end
`ifndef CDB_RR_EN
    check("fixed_rob9_waits", 64'(saw9), 64'd0);
    check("fixed_src0_ready", 64'(r0_low), 64'd0);
`endif
    idle();
    for (int c = 0; c < 8 && !saw9; c++) begin
      step();
      if (last_valid && last_rob == 4'd9) saw9 = 1'b1;
    end
    check("rob9_delivered", 64'(saw9), 64'd1);

    // Full and flush: src0 and src1 push every cycle.
    do_clear();
    dropped = 1'b0;
    seq0    = 0;
    seq1    = 0;
    for (int c = 0; c < 5; c++) begin
      set_src(0, 1'b1, RW'(seq0), 32'(32'hB000 + seq0));
      set_src(1, 1'b1, RW'(seq1 + 8), 32'(32'hC000 + seq1));
      step();
      if (last_acc[0]) seq0++;
      if (last_acc[1]) seq1++;
      if (last_ready[1:0] != 2'b11) dropped = 1'b1;
    end
    check("full_ready_drop", 64'(dropped), 64'd1);
    rob_clear = 1'b1;
    step();
    rob_clear = 1'b0;
    idle();
    step();
    check("flush_src_ready", 64'(last_ready), 64'b111);
    check("flush_cdb_valid", 64'(last_valid), 64'd0);
    step();
    check("flush_stay_idle", 64'(last_valid), 64'd0);

    // Stall: rdy_in low for 3 cycles (a rob_clear during the stall is ignored).
    do_clear();
    set_src(0, 1'b1, 4'd4, 32'h4444);
    set_src(1, 1'b1, 4'd6, 32'h6666);
    step();
    idle();
    rdy_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      rob_clear = (c == 1);
      step();
      check("stall_valid", 64'(last_valid), 64'd0);
      check("stall_ready", 64'(last_ready), 64'd0);
    end
    rob_clear = 1'b0;
    rdy_in    = 1'b1;
    step();
    check("stall_rob4", 64'(last_rob), 64'd4);
    check("stall_val4", 64'(last_value), 64'h4444);
    step();
    check("stall_rob6", 64'(last_rob), 64'd6);
    check("stall_val6", 64'(last_value), 64'h6666);
    step();
    check("stall_drained", 64'(last_valid), 64'd0);

    // Randomized traffic; producers hold until accepted.
    do_clear();
    pend = '0;
    for (int c = 0; c < 400; c++) begin
      rdy_in    = ($urandom_range(0, 7) != 0);
      rob_clear = ($urandom_range(0, 39) == 0);
      for (int k = 0; k < NS; k++) begin
        if (!pend[k]) begin
          if ($urandom_range(0, 2) != 0) begin
            set_src(k, 1'b1, RW'($urandom_range(0, 15)), $urandom);
            pend[k] = 1'b1;
          end else begin
            src_valid[k] = 1'b0;
          end
        end
      end
      step();
      for (int k = 0; k < NS; k++)
        if (last_acc[k] || (rob_clear && rdy_in)) pend[k] = 1'b0;
    end
    idle();
    rob_clear = 1'b0;
    rdy_in    = 1'b1;
    for (int c = 0; c < 8; c++) step();
    check("random_drained", 64'(last_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common-data-bus arbiter between the execution units and the reservation station, load/store buffer and ROB. It accepts result broadcasts from N producers (ALU in the RS, LSB, future units), buffers each producer in a small per-source queue, and drives one shared result bus per cycle. The bus carries one result per cycle, so every consumer compares against only one tag. The arbiter selects the winner by round-robin or fixed priority.

## Interface
- N_SRC, 3: number of result producers; index 0 = ALU, 1 = LSB, 2 = spare.
- QDEPTH, 2: entries per source queue; power of two, at least 2.
- ROB_W, width of `ROB_R: ROB tag width.

Ports:
- clk_in  input  1  clock; all state updates on posedge.
- rst_in  input  1  synchronous, active-high reset.
- rdy_in  input  1  global ready; low freezes all state.
- rob_clear  input  1  misprediction flush.
- src_valid  input  N_SRC  per-source result valid.
- src_rob_id  input  N_SRC*ROB_W  per-source tag; source k occupies bits [k*ROB_W +: ROB_W].
- src_value  input  N_SRC*32  per-source result; source k occupies bits [k*32 +: 32].
- src_ready  output  N_SRC  per-source queue not full.
- cdb_valid  output  1  broadcast valid this cycle.
- cdb_rob_id  output  ROB_W  broadcast tag.
- cdb_value  output  32  broadcast value.

## Operation
- Push: source k is written at the posedge when src_valid[k] && src_ready[k] && rdy_in && !rob_clear.
  - If src_valid[k] is high while src_ready[k] is low, the producer must hold the result; the arbiter drops nothing silently.
- src_ready[k] = rdy_in && (count[k] != QDEPTH).
  - Depends on registered count only; a pop in the same cycle does not raise it.
- Grant: combinational over queue heads. Eligible sources are those with count[k] != 0. Exactly one grant when any source is eligible and rdy_in = 1.
- Output: cdb_valid = rdy_in && any eligible. cdb_rob_id / cdb_value = head of the granted queue.
  - When cdb_valid = 0, the data outputs are don't-care; they are driven with the source 0 head.
- Pop: the granted queue's head is removed at the same posedge. The CDB has no back-pressure; consumers always accept.
- Simultaneous push and pop on one queue: both take effect; count is unchanged.
- Queue wrap: read/write pointers are log2(QDEPTH) bits and wrap modulo QDEPTH. count is log2(QDEPTH)+1 bits.
- Per-source order is FIFO. Order across sources is defined only by arbitration.
- rob_clear (with rdy_in high): all counts and pointers go to 0, rr_ptr goes to 0, and inputs in that cycle are discarded. cdb_valid still shows the current head during the clear cycle; consumers also clear and ignore it.
- rst_in: same effect as rob_clear, with priority over rdy_in and all other inputs.
- rdy_in low: no push, no pop, no pointer change. cdb_valid = 0 and src_ready = 0.

## Timing
- Reset values: cdb_valid 0; src_ready all 1 once rdy_in is high; counts 0; rr_ptr 0.
- Latency: a result pushed at posedge t can appear on the CDB in the cycle after t, if it wins arbitration. This is a 1-cycle minimum from src_valid to cdb_valid.
- Throughput: one broadcast per cycle in aggregate; one push per source per cycle.
- A source that pushes every cycle while losing arbitration sees src_ready fall after QDEPTH pushes beyond its pops.

## Configuration
- CDB_RR_EN defined: round-robin arbitration.
  - rr_ptr (log2(N_SRC) bits) marks the highest-priority source; search runs rr_ptr, rr_ptr+1, … modulo N_SRC.
  - After a grant to source k, rr_ptr becomes (k+1) mod N_SRC.
  - rr_ptr is unchanged when nothing is granted or rdy_in is low.
- CDB_RR_EN undefined: fixed priority, lowest index wins. rr_ptr is absent.

## Structure
- ROB_W comes from `ROB_R in const.v.
- Add to const.v: `CDB_NSRC (3), `CDB_SRC_ALU (0), `CDB_SRC_LSB (1).
- One sub-module, cdb_fifo:
  - parameterised by width and depth;
  - provides push, pop, flush, head, count and full;
  - instantiated N_SRC times in a generate loop.
- Arbitration logic stays in cdb_arbiter.

## Test plan
All scenarios use N_SRC=3, QDEPTH=2.
- Reset: rst_in high 2 cycles, then rdy_in=1 → cdb_valid=0, src_ready=3'b111.
- Single push: src1 sends rob 5, value 0x1234 at cycle 0 → cycle 1 cdb_valid=1, rob 5, value 0x1234; cycle 2 cdb_valid=0.
- Three-way collision: sources 0/1/2 push rob 1/2/3 in the same cycle → tags 1, 2, 3 on cycles 1, 2, 3 in either mode; cycle 4 idle.
- Contention:
  - Stimulus: src0 pushes every cycle from cycle 0; src2 pushes rob 9 once at cycle 0.
  - With CDB_RR_EN: rob 9 is broadcast by cycle 2.
  - Without CDB_RR_EN: rob 9 waits while src0 is non-empty, and src_ready[0] never drops.
- Full and flush:
  - Stimulus: src0 and src1 push every cycle.
  - src_ready for the losing source drops to 0 after it holds 2 entries.
  - Asserting rob_clear → next cycle all counts are 0, src_ready=3'b111, and cdb_valid=0 until a new push.
- Stall: queue entries rob 4 on src0 and rob 6 on src1, then rdy_in=0 for 3 cycles → cdb_valid=0 and src_ready=0 throughout; after rdy_in rises, rob 4 then rob 6 are broadcast with values intact.
